serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor: accepts two WIDTH-bit operands over a valid/ready handshake and computes D = x - y one bit per clock, LSB first.
- Uses a single full-subtractor cell and a borrow flip-flop.
- Returns the difference and the final borrow over a second valid/ready handshake.
- It is the subtracting counterpart of the team's adder cells and serves area-constrained datapaths where one result per WIDTH+2 cycles is sufficient.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk      input   1      rising-edge clock
- rst_n    input   1      synchronous, active-low reset
- in_valid input   1      operands x, y valid
- in_ready output  1      block can accept operands
- x        input   WIDTH  minuend (unsigned)
- y        input   WIDTH  subtrahend (unsigned)
- out_valid output 1      D, B valid
- out_ready input  1      consumer accepts result
- D        output  WIDTH  difference, (x - y) mod 2^WIDTH
- B        output  1      final borrow; 1 iff x < y unsigned

Behaviour:
- One clock (clk); reset is synchronous, active-low (rst_n), sampled on the rising edge of clk only.
- Reset values: in_ready=0 while rst_n=0, then 1 in IDLE; out_valid=0, D=0, B=0; state=IDLE; bit counter=0; borrow FF=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1, out_valid=0. On in_valid && in_ready at an edge: latch x, y into shift registers, clear borrow FF, clear counter, go to BUSY.
  - BUSY: in_ready=0. Each cycle apply the full-subtractor to xs[0], ys[0], b:
    - d = xs[0]^ys[0]^b
    - b' = (~xs[0] & ys[0]) | (~(xs[0]^ys[0]) & b)
    - Shift xs and ys right by 1, shift d into the result register at the MSB, and increment the counter.
    - When the counter is WIDTH-1 at the edge, go to DONE, with B = b' of that final bit.
  - DONE: out_valid=1; D and B are held stable until out_ready=1 at an edge, then go to IDLE.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
  - in_ready returns 1 on the cycle after the output handshake.
  - Minimum issue interval is WIDTH+2 cycles.
- in_valid is ignored in BUSY/DONE. Changes on x, y after acceptance have no effect.
- In DONE with out_ready held 0 indefinitely: all outputs remain frozen. No overrun or drop is possible.
- Reset mid-operation (any state): the operation is aborted and discarded; next cycle all outputs are at their reset values.
- D is not guaranteed meaningful outside DONE; verification checks D and B only when out_valid=1.
- Counter width: $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- When defined:
  - Adds output port V (1 bit), signed two's-complement overflow, V = (x[MSB]^y[MSB]) & (x[MSB]^D[MSB]).
  - V is computed from the latched operand MSBs and is valid and stable with out_valid; reset value 0.
- When undefined: port V and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_subtractor_pkg holds the FSM state typedef (IDLE, BUSY, DONE) and the state encoding constants.
- One sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), is instantiated once for the per-bit cell. Everything else lives in the top module.

Test Plan:
- WIDTH=8, x=0x5A, y=0x23 -> D=0x37, B=0; out_valid exactly 8 cycles after accept.
- x=0x00, y=0x01 -> D=0xFF, B=1. Then x=0xFF, y=0xFF -> D=0x00, B=0.
- Back-pressure: x=0x10, y=0x01 with out_ready=0 for 5 cycles in DONE -> D=0x0F, B=0, out_valid=1 stable and in_ready=0 throughout. On out_ready=1, in_ready=1 on the next cycle. in_valid pulses during BUSY are ignored.
- Reset mid-operation: rst_n=0 for 1 cycle at bit 4 of x=0xAA, y=0x55 -> next cycle out_valid=0, D=0, B=0. After release in_ready=1, and a fresh x=0xAA, y=0x55 gives D=0x55, B=0.
- Back-to-back: 3 operations with in_valid held high and out_ready=1 -> each accepted WIDTH+2 cycles apart, results in order and correct.
- With SERIAL_SUBTRACTOR_OVF_EN:
  - x=0x80, y=0x01 -> D=0x7F, B=0, V=1.
  - x=0x7F, y=0xFF -> D=0x80, B=1, V=1.
  - x=0x05, y=0x03 -> V=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module  : serial_subtractor_pkg
// Purpose : Shared FSM state type and encodings for the bit-serial subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_busy = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  typedef enum logic [1:0] {
    IDLE = c_st_idle,
    BUSY = c_st_busy,
    DONE = c_st_done
  } state_t;

  // Bit-counter width; WIDTH >= 2 keeps this at least one bit wide.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fs.sv
// ============================================================================
// Module  : full_subtractor
// Purpose : One-bit full subtractor cell, d = a - b - bin with borrow out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Purpose : Bit-serial unsigned subtractor D = x - y, LSB first, with borrow.
//           Optional signed-overflow output V under SERIAL_SUBTRACTOR_OVF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             B
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int              CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0]   c_last = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_xs;
  logic [WIDTH-1:0] r_ys;
  logic [WIDTH-1:0] r_d;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_d;
  logic             w_bout;

  full_subtractor u_fs (
    .a    (r_xs[0]),
    .b    (r_ys[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (r_cnt == c_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath: operands shift out LSB first, result bits enter at the MSB so the
  // first computed bit lands in D[0] after WIDTH shifts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xs     <= '0;
      r_ys     <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_xs     <= x;
      r_ys     <= y;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == BUSY) begin
      r_xs     <= {1'b0, r_xs[WIDTH-1:1]};
      r_ys     <= {1'b0, r_ys[WIDTH-1:1]};
      r_d      <= {w_d, r_d[WIDTH-1:1]};
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign D = r_d;
  assign B = r_borrow;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_xmsb;
  logic r_ymsb;

  // Operand MSBs are shifted away during BUSY, so keep copies for V.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xmsb <= 1'b0;
      r_ymsb <= 1'b0;
    end else if (w_accept) begin
      r_xmsb <= x[WIDTH-1];
      r_ymsb <= y[WIDTH-1];
    end
  end

  assign V = (r_xmsb ^ r_ymsb) & (r_xmsb ^ r_d[WIDTH-1]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Purpose : Self-checking bench for serial_subtractor (WIDTH = 8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] D;
  logic         B;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         V;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .B         (B)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .V         (V)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] d;
    logic         b;
    logic         v;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got D=%0h with empty scoreboard", D);
      end else begin
        e = q.pop_front();
        chk("result_D", 32'(D), 32'(e.d));
        chk("result_B", 32'(B), 32'(e.b));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("result_V", 32'(V), 32'(e.v));
`endif
      end
    end
  end

  task automatic wait_ready(input string nm);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Drive one operation; returns at posedge+1 after acceptance, or after
  // the first DONE cycle when the latency is checked.
  task automatic do_op(input vec_t v, input bit lat, input bit poke);
    exp_t e;
    @(posedge clk); #1;
    x = v.x; y = v.y; in_valid = 1'b1;
    wait_ready("op");
    e.d = v.d; e.b = v.b; e.v = v.v;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom);
    if (lat) begin
      if (poke) in_valid = 1'b1;
      repeat (W - 1) @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk) chk("latency_not_early", 32'(out_valid), 32'd0);
      @(negedge clk) chk("latency_exact", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  vec_t tbl[6];
  vec_t bb[3];
  int   t_acc[3];

  initial begin
    tbl[0] = '{x: 8'h5A, y: 8'h23, d: 8'h37, b: 1'b0, v: 1'b0};
    tbl[1] = '{x: 8'h00, y: 8'h01, d: 8'hFF, b: 1'b1, v: 1'b0};
    tbl[2] = '{x: 8'hFF, y: 8'hFF, d: 8'h00, b: 1'b0, v: 1'b0};
    tbl[3] = '{x: 8'h80, y: 8'h01, d: 8'h7F, b: 1'b0, v: 1'b1};
    tbl[4] = '{x: 8'h7F, y: 8'hFF, d: 8'h80, b: 1'b1, v: 1'b1};
    tbl[5] = '{x: 8'h05, y: 8'h03, d: 8'h02, b: 1'b0, v: 1'b0};
    bb[0]  = '{x: 8'hC3, y: 8'h3C, d: 8'h87, b: 1'b0, v: 1'b0};
    bb[1]  = '{x: 8'h12, y: 8'h34, d: 8'hDE, b: 1'b1, v: 1'b0};
    bb[2]  = '{x: 8'hFE, y: 8'h01, d: 8'hFD, b: 1'b0, v: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; x = '0; y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_D", 32'(D), 32'd0);
    chk("reset_B", 32'(B), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("reset_V", 32'(V), 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk) chk("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 6; i++) do_op(tbl[i], 1'b1, 1'b0);

    // Back-pressure with in_valid poked during BUSY.
    out_ready = 1'b0;
    do_op('{x: 8'h10, y: 8'h01, d: 8'h0F, b: 1'b0, v: 1'b0}, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_D", 32'(D), 32'h0F);
      chk("bp_B", 32'(B), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk) chk("bp_handshake_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) chk("bp_after_in_ready", 32'(in_ready), 32'd1);

    // Reset at bit 4 of an operation.
    @(posedge clk); #1;
    x = 8'hAA; y = 8'h55; in_valid = 1'b1;
    wait_ready("rst_op");
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk) chk("midrst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_D", 32'(D), 32'd0);
    chk("midrst_B", 32'(B), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    do_op('{x: 8'hAA, y: 8'h55, d: 8'h55, b: 1'b0, v: 1'b1}, 1'b1, 1'b0);

    // Back-to-back with in_valid held high.
    @(posedge clk); #1;
    in_valid = 1'b1; x = bb[0].x; y = bb[0].y;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      wait_ready("b2b");
      e.d = bb[k].d; e.b = bb[k].b; e.v = bb[k].v;
      q.push_back(e);
      t_acc[k] = cyc;
      @(posedge clk); #1;
      if (k < 2) begin
        x = bb[k+1].x; y = bb[k+1].y;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk("b2b_interval_0", 32'(t_acc[1] - t_acc[0]), 32'(W + 2));
    chk("b2b_interval_1", 32'(t_acc[2] - t_acc[1]), 32'(W + 2));

    for (int g = 0; g < 200 && q.size() != 0; g++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
